xdiv_master: RTL and testbench

Bus initiator that drives the memory-mapped divider peripheral on behalf of a client. It accepts a dividend/divisor pair on a valid/ready request port, runs the peripheral's register sequence (load operands, pulse start, poll done, read results), and returns quotient and remainder on a valid/ready response port. It sits between a computation client and the peripheral's `addr`/`dividersel`/`data`/`dataout` port, replacing software polling.

---
 rtl/xdiv_master_pkg.sv | 29 ++
 rtl/xdiv_master_if.sv | 35 +++
 rtl/xdiv_master.sv | 158 +++++++++++++++
 tb/tb_xdiv_master.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xdiv_master_pkg.sv
// Shared definitions for xdiv_master: divider peripheral register map,
// controller state encoding and the default poll timeout.
package xdiv_master_pkg;

    // Peripheral register addresses
    localparam logic [2:0] ADDR_DIVIDEND  = 3'd0;
    localparam logic [2:0] ADDR_DIVISOR   = 3'd1;
    localparam logic [2:0] ADDR_REMAINDER = 3'd2;
    localparam logic [2:0] ADDR_QUOTIENT  = 3'd3;
    localparam logic [2:0] ADDR_START     = 3'd4;
    localparam logic [2:0] ADDR_DONE      = 3'd5;

    // Cycles allowed in the poll states before giving up
    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_DVD,
        S_WR_DVS,
        S_START_HI,
        S_START_LO,
        S_WAIT_LO,
        S_WAIT_HI,
        S_RD_REM,
        S_RD_QUO,
        S_RESP
    } xdiv_state_e;

endpackage

// File: rtl/xdiv_master_if.sv
// Client request/response ports and peripheral register bus of xdiv_master.
//
// Handshake rule for both req_* and rsp_*: a transfer happens on a rising
// clk edge where valid && ready are both high; the sender holds valid and
// its payload stable until that edge, and ready never depends on a
// combinational path from valid.
interface xdiv_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_dividend;
    logic [31:0] req_divisor;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_quotient;
    logic [31:0] rsp_remainder;
    logic        rsp_err;
    logic [2:0]  bus_addr;
    logic        bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    // Side of the divider controller (bus initiator)
    modport master (
        input  req_valid, req_dividend, req_divisor, rsp_ready, bus_rdata,
        output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
        output bus_addr, bus_sel, bus_wdata
    );

    // Side of the client plus peripheral
    modport slave (
        output req_valid, req_dividend, req_divisor, rsp_ready, bus_rdata,
        input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
        input  bus_addr, bus_sel, bus_wdata
    );
endinterface

// File: rtl/xdiv_master.sv
// xdiv_master: runs the memory-mapped divider's register sequence
// (load operands, pulse start, poll done, read results) for one client
// request at a time and returns quotient/remainder.
// Optional feature macro: XDIV_MASTER_DIVZERO_EN -- when defined, a zero
// divisor is answered directly from IDLE (quotient all ones, remainder =
// dividend, rsp_err set) without touching the bus.
module xdiv_master
    import xdiv_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    xdiv_master_if.master io,
    output xdiv_state_e   dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    xdiv_state_e      state_q, state_d;
    logic [31:0]      dvd_q, dvd_d;
    logic [31:0]      dvs_q, dvs_d;
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      rem_q, rem_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       bus_addr_c;
    logic             bus_sel_c;
    logic [31:0]      bus_wdata_c;

    // State register and datapath flops; peripheral shares rst so no cleanup
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, captured results and bus drive decoded from current state
    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        bus_addr_c  = ADDR_DONE;
        bus_sel_c   = 1'b0;
        bus_wdata_c = '0;

        case (state_q)
            S_IDLE: begin
                if (io.req_valid) begin
                    dvd_d   = io.req_dividend;
                    dvs_d   = io.req_divisor;
                    err_d   = 1'b0;
                    state_d = S_WR_DVD;
`ifdef XDIV_MASTER_DIVZERO_EN
                    // Trap divide-by-zero locally with the restoring-divider result
                    if (io.req_divisor == 32'd0) begin
                        quo_d   = 32'hFFFF_FFFF;
                        rem_d   = io.req_dividend;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
`endif
                end
            end
            S_WR_DVD: begin
                bus_addr_c  = ADDR_DIVIDEND;
                bus_sel_c   = 1'b1;
                bus_wdata_c = dvd_q;
                state_d     = S_WR_DVS;
            end
            S_WR_DVS: begin
                bus_addr_c  = ADDR_DIVISOR;
                bus_sel_c   = 1'b1;
                bus_wdata_c = dvs_q;
                state_d     = S_START_HI;
            end
            S_START_HI: begin
                bus_addr_c  = ADDR_START;
                bus_sel_c   = 1'b1;
                bus_wdata_c = 32'd1;
                state_d     = S_START_LO;
            end
            S_START_LO: begin
                // Start is level-held in the peripheral: drop it again
                bus_addr_c  = ADDR_START;
                bus_sel_c   = 1'b1;
                bus_wdata_c = 32'd0;
                cnt_d       = '0;
                state_d     = S_WAIT_LO;
            end
            S_WAIT_LO, S_WAIT_HI: begin
                // Done still shows the previous result until it is seen low
                cnt_d = cnt_q + CNT_W'(1);
                if (state_q == S_WAIT_LO && !io.bus_rdata[0]) begin
                    state_d = S_WAIT_HI;
                end else if (state_q == S_WAIT_HI && io.bus_rdata[0]) begin
                    state_d = S_RD_REM;
                end else if (cnt_q == CNT_LAST) begin
                    quo_d   = '0;
                    rem_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RD_REM: begin
                bus_addr_c = ADDR_REMAINDER;
                rem_d      = io.bus_rdata;
                state_d    = S_RD_QUO;
            end
            S_RD_QUO: begin
                bus_addr_c = ADDR_QUOTIENT;
                quo_d      = io.bus_rdata;
                state_d    = S_RESP;
            end
            S_RESP: begin
                // Idle read only while the client holds the response
                bus_addr_c = ADDR_QUOTIENT;
                if (io.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign io.req_ready     = (state_q == S_IDLE);
    assign io.rsp_valid     = (state_q == S_RESP);
    assign io.rsp_quotient  = quo_q;
    assign io.rsp_remainder = rem_q;
    assign io.rsp_err       = err_q;
    assign io.bus_addr      = bus_addr_c;
    assign io.bus_sel       = bus_sel_c;
    assign io.bus_wdata     = bus_wdata_c;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_xdiv_master.sv
// Self-checking bench for xdiv_master with a behavioural 32-step divider
// peripheral attached to its register bus.
module tb_xdiv_master;
    import xdiv_master_pkg::*;

`ifdef XDIV_MASTER_DIVZERO_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    xdiv_master_if io();
    xdiv_state_e dbg_state;

    xdiv_master dut (
        .clk       (clk),
        .rst       (rst),
        .io        (io),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sel_cnt = 0;
    int acc_cyc = 0;
    bit stuck_done = 1'b0;
    logic [64:0] exp_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (io.bus_sel) sel_cnt <= sel_cnt + 1;
    end

    // Behavioural divider peripheral: start latched, one load cycle, 32 steps
    logic [31:0] p_dvd, p_dvs, p_quo, p_rem;
    logic        p_start, p_done;
    int          p_phase, p_cnt;

    always @(posedge clk) begin
        if (rst) begin
            p_dvd <= '0; p_dvs <= '0; p_quo <= '0; p_rem <= '0;
            p_start <= 1'b0; p_done <= 1'b1; p_phase <= 0; p_cnt <= 0;
        end else begin
            if (io.bus_sel) begin
                case (io.bus_addr)
                    3'd0: p_dvd <= io.bus_wdata;
                    3'd1: p_dvs <= io.bus_wdata;
                    3'd4: p_start <= io.bus_wdata[0];
                    default: ;
                endcase
            end
            if (p_phase == 0 && p_start) begin
                p_phase <= 1;
            end else if (p_phase == 1) begin
                p_done <= 1'b0;
                p_cnt <= 32;
                p_phase <= 2;
                if (p_dvs == 0) begin
                    p_quo <= 32'hFFFF_FFFF;
                    p_rem <= p_dvd;
                end else begin
                    p_quo <= p_dvd / p_dvs;
                    p_rem <= p_dvd % p_dvs;
                end
            end else if (p_phase == 2) begin
                p_cnt <= p_cnt - 1;
                if (p_cnt == 1) begin
                    p_done <= 1'b1;
                    p_phase <= 0;
                end
            end
        end
    end

    always_comb begin
        case (io.bus_addr)
            3'd2:    io.bus_rdata = p_rem;
            3'd3:    io.bus_rdata = p_quo;
            3'd5:    io.bus_rdata = {31'd0, p_done | stuck_done};
            default: io.bus_rdata = '0;
        endcase
    end

    // Reference model: {err, quotient, remainder}
    function automatic logic [64:0] model(input logic [31:0] dvd, input logic [31:0] dvs);
        if (dvs == 32'd0) return {DZ_EN, 32'hFFFF_FFFF, dvd};
        return {1'b0, dvd / dvs, dvd % dvs};
    endfunction

    function automatic int model_lat(input logic [31:0] dvs);
        return (DZ_EN && dvs == 32'd0) ? 1 : 41;
    endfunction

    function automatic int model_sel(input logic [31:0] dvs);
        return (DZ_EN && dvs == 32'd0) ? 0 : 4;
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while the DUT is in IDLE; returns at the negedge
    // after the response handshake (DUT back in IDLE).
    task automatic send_req(input logic [31:0] dvd, input logic [31:0] dvs, input int stall,
                            input int exp_lat, input int exp_sel, input string tag);
        int lat;
        int w;
        int sel0;
        logic [64:0] exp;
        logic [31:0] q0, r0;
        exp = exp_q.pop_front();
        w = 0;
        while (!io.req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_req_ready"}, 65'(io.req_ready), 65'(1));
        sel0 = sel_cnt;
        acc_cyc = cyc;
        io.req_valid = 1'b1;
        io.req_dividend = dvd;
        io.req_divisor = dvs;
        @(negedge clk);
        io.req_valid = 1'b0;
        lat = 1;
        while (!io.rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 65'(lat), 65'(exp_lat));
        chk({tag, "_result"}, {io.rsp_err, io.rsp_quotient, io.rsp_remainder}, exp);
        q0 = io.rsp_quotient;
        r0 = io.rsp_remainder;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_hold_data"}, {io.rsp_err, io.rsp_quotient, io.rsp_remainder}, {exp[64], q0, r0});
            chk({tag, "_hold_ctl"}, 65'({io.rsp_valid, io.req_ready, io.bus_sel,
                                         io.bus_addr == 3'd2 || io.bus_addr == 3'd3}),
                65'(4'b1001));
        end
        io.rsp_ready = 1'b1;
        @(negedge clk);
        io.rsp_ready = 1'b0;
        chk({tag, "_sel_pulses"}, 65'(sel_cnt - sel0), 65'(exp_sel));
        chk({tag, "_back_idle"}, 65'({io.rsp_valid, io.req_ready}), 65'(2'b01));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        logic [31:0] dvd, dvs;
        io.req_valid = 1'b0;
        io.req_dividend = '0;
        io.req_divisor = '0;
        io.rsp_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_handshake", 65'({io.req_ready, io.rsp_valid, io.rsp_err}), 65'(3'b100));
        chk("reset_results", {1'b0, io.rsp_quotient, io.rsp_remainder}, 65'(0));
        chk("reset_bus", {io.bus_sel, io.bus_addr, io.bus_wdata}, 65'({1'b0, 3'd5, 32'd0}));
        rst = 1'b0;

        // Basic division against the peripheral
        exp_q.push_back(model(32'd100, 32'd7));
        chk("model_100_7", model(32'd100, 32'd7), {1'b0, 32'd14, 32'd2});
        send_req(32'd100, 32'd7, 0, 41, 4, "div_100_7");

        // Back-to-back extremes, with throughput of one per 42 cycles
        exp_q.push_back(model(32'hFFFF_FFFF, 32'd1));
        send_req(32'hFFFF_FFFF, 32'd1, 0, 41, 4, "div_max_1");
        a1 = acc_cyc;
        exp_q.push_back(model(32'h8000_0000, 32'hFFFF_FFFF));
        send_req(32'h8000_0000, 32'hFFFF_FFFF, 0, 41, 4, "div_msb_max");
        chk("throughput", 65'(acc_cyc - a1), 65'(42));

        // Divide by zero
        exp_q.push_back(model(32'd5, 32'd0));
        send_req(32'd5, 32'd0, 0, model_lat(32'd0), model_sel(32'd0), "div_5_0");

        // Client stalls the response for 10 cycles
        exp_q.push_back(model(32'd1234567, 32'd89));
        send_req(32'd1234567, 32'd89, 10, 41, 4, "stall10");

        // Done stuck high: timeout after 64 WAIT_LO cycles
        stuck_done = 1'b1;
        exp_q.push_back({1'b1, 64'd0});
        send_req(32'd1000, 32'd10, 0, 69, 4, "timeout");
        stuck_done = 1'b0;

        // Reset during WAIT_HI, then a fresh request
        io.req_valid = 1'b1;
        io.req_dividend = 32'd123456;
        io.req_divisor = 32'd7;
        @(negedge clk);
        io.req_valid = 1'b0;
        repeat (19) @(negedge clk);
        chk("in_wait_hi", 65'(dbg_state), 65'(S_WAIT_HI));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_idle", 65'({io.req_ready, io.rsp_valid, io.bus_sel, io.bus_addr}),
            65'({1'b1, 1'b0, 1'b0, 3'd5}));
        chk("rst_state", 65'(dbg_state), 65'(S_IDLE));
        rst = 1'b0;
        exp_q.push_back(model(32'd9, 32'd3));
        send_req(32'd9, 32'd3, 0, 41, 4, "div_9_3");

        // Randomized requests against the model
        for (int n = 0; n < 10; n++) begin
            dvd = $urandom;
            case ($urandom_range(0, 3))
                0:       dvs = 32'd0;
                1:       dvs = $urandom_range(1, 15);
                default: dvs = $urandom;
            endcase
            exp_q.push_back(model(dvd, dvs));
            send_req(dvd, dvs, $urandom_range(0, 3), model_lat(dvs), model_sel(dvs), "rand");
        end

        chk("scoreboard_empty", 65'(exp_q.size()), 65'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
